// File: rtl/line_memory_model.sv
// Cacheline-granular memory model for the core's cache/arbiter port: configurable
// line width, depth and read/write latency, with protocol checking and transaction counters.
module line_memory_model #(
  parameter int LINE_BITS     = 256,
  parameter int ADDR_BITS     = 32,
  parameter int DEPTH_LINES   = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [LINE_BITS-1:0] wdata,
  output logic                 resp,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 error,
  output logic                 busy,
  output logic [31:0]          read_count,
  output logic [31:0]          write_count
);
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDXW  = $clog2(DEPTH_LINES);
  localparam int HI    = OFF + IDXW;
  localparam int CNT_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic [31:0]          rd_cnt_q, rd_cnt_d;
  logic [31:0]          wr_cnt_q, wr_cnt_d;
  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 oor_q, oor_d;
  logic [CNT_W-1:0]     lat_m1;

  assign idx_q  = addr_q[OFF +: IDXW];
  assign oor_q  = (addr_q >> HI) != '0;
  assign idx_d  = addr_d[OFF +: IDXW];
  assign oor_d  = (addr_d >> HI) != '0;
  assign lat_m1 = write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (read && write) begin
          error_d = 1'b1;
        end else if (read ^ write) begin
          op_wr_d = write;
          addr_d  = address;
          wdata_d = wdata;
          cnt_d   = lat_m1;
          state_d = (lat_m1 == '0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        // Requester must hold the request steady; deviations are flagged but ignored.
        if ((read == op_wr_q) || (write != op_wr_q) || (address != addr_q)) error_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (oor_q) error_d = 1'b1;
        if (op_wr_q) wr_cnt_d = wr_cnt_q + 32'd1;
        else         rd_cnt_d = rd_cnt_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // Read data is captured on entry to RESP so it is valid for the whole resp cycle.
    if (state_d == S_RESP && state_q != S_RESP && !op_wr_d)
      rdata_d = oor_d ? '0 : mem_q[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage is not reset; a reset during a transaction leaves state_q in IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && op_wr_q && !oor_q) mem_q[idx_q] <= wdata_q;
  end

  assign resp        = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign rdata       = rdata_q;
  assign error       = error_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
endmodule

// File: doc/line_memory_model.md
Name: line_memory_model

Overview:
- Parametrised cacheline-granular physical memory for the pipelined RV32I core's cache/arbiter memory port; replaces the fixed-latency, fixed-width model in the top-level bench.
- Adds configurable line width, depth, and separate read/write latency.
- Adds protocol checking (simultaneous read/write, request changed mid-transaction, out-of-range address) with a sticky error flag.
- Adds read/write transaction counters for bench statistics.

Parameters:
LINE_BITS, 256, line width in bits; power of two, >= 32
ADDR_BITS, 32, byte address width
DEPTH_LINES, 1024, number of lines stored; power of two
READ_LATENCY, 4, cycles from request acceptance to read resp; >= 1
WRITE_LATENCY, 4, cycles from request acceptance to write resp; >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
read  in  1  read request; held until resp
write  in  1  write request; held until resp
address  in  ADDR_BITS  byte address; low log2(LINE_BITS/8) bits ignored
wdata  in  LINE_BITS  write line data
resp  out  1  single-cycle completion pulse
rdata  out  LINE_BITS  read line data; valid while resp=1
error  out  1  sticky protocol/range error
busy  out  1  transaction in flight
read_count  out  32  completed read transactions
write_count  out  32  completed write transactions

Behaviour:
- Reset (async, rst_n=0): state IDLE; resp=0, rdata=0, error=0, busy=0, both counters 0; latency counter 0; latched request cleared. Storage array is not reset.
- Reset asserted mid-transaction aborts it: no resp, no write commit.
- Line index = address[OFF+log2(DEPTH_LINES)-1 : OFF], where OFF = log2(LINE_BITS/8).
- Out of range: any set address bit at or above OFF+log2(DEPTH_LINES).
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - read^write at a rising edge: latch op, address, wdata; load counter with (op latency - 1); busy=1; go to BUSY.
  - read&write both high: set error; stay IDLE; no resp.
- BUSY:
  - Counter decrements each cycle. At 0, go to RESP.
  - Each cycle, compare live read, write and address against the latched values. Any mismatch (deassert, op change, address change) sets error; the transaction still completes using the latched values.
  - wdata is latched at acceptance; later wdata changes are ignored.
- RESP:
  - resp=1 for exactly one cycle; busy stays 1; FSM returns to IDLE next edge.
  - Read: rdata = array[index] (zero if out of range); rdata holds its value after resp drops, until the next read resp.
  - Write: array[index] <= latched wdata at the edge that ends the RESP cycle; discarded if out of range.
  - Out of range also sets error.
  - The matching counter increments at the end of the RESP cycle; 32-bit wrap from FFFF_FFFF to 0.
- Timing: request sampled at edge N → resp high in cycle N+LAT.
  - LAT=1 means resp in the cycle right after acceptance: BUSY lasts 0 cycles, go directly to RESP.
- Back-to-back: a request visible in the cycle after resp (FSM back in IDLE) is a new transaction. A request held through resp is therefore re-accepted; requesters must drop read/write in the resp cycle.
- Read-after-write to the same line returns the newly written data.
- error is sticky until reset and never blocks operation.

Test Plan:
- Write line 0x40 with wdata={8{32'hDEADBEEF}} (WRITE_LATENCY=4), then read 0x40 (READ_LATENCY=4) → resp exactly 4 cycles after each acceptance, rdata={8{32'hDEADBEEF}}, write_count=1, read_count=1, error=0.
- Read address 0x5F (same line as 0x40) → same data; low 5 bits ignored.
- With DEPTH_LINES=1024, LINE_BITS=256, read 0x8000 → resp after latency, rdata=0, error=1. Write to 0x8000, then read 0x0 → line 0 unchanged.
- Assert read and write together in IDLE → error=1, no resp, counters unchanged.
- Change address from 0x40 to 0x80 two cycles into a read → error=1, resp still occurs, rdata=line 0x40.
- Assert rst_n=0 mid-write, then read the line → old data returned; all outputs 0 during reset. Separately, LAT=1 build → resp in the cycle after acceptance, back-to-back reads complete every 2 cycles.
